// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline control unit: opcodes, FSM states,
// forwarding selects and instruction-register field positions.
package pipe_pkg;

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_SW   = 5'd1;
    localparam logic [4:0] OP_LW   = 5'd2;
    localparam logic [4:0] OP_BEQ  = 5'd3;
    localparam logic [4:0] OP_JMP  = 5'd4;
    localparam logic [4:0] OP_HALT = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STALL = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EXE = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    localparam int unsigned IR_OPC_LSB = 27;
    localparam int unsigned IR_RS1_LSB = 17;
    localparam int unsigned IR_RS2_LSB = 12;
    localparam int unsigned IR_FLD_W   = 5;

    function automatic logic [4:0] ir_opcode(input logic [31:0] ir);
        return ir[IR_OPC_LSB +: IR_FLD_W];
    endfunction

    function automatic logic [4:0] ir_rs1(input logic [31:0] ir);
        return ir[IR_RS1_LSB +: IR_FLD_W];
    endfunction

    function automatic logic [4:0] ir_rs2(input logic [31:0] ir);
        return ir[IR_RS2_LSB +: IR_FLD_W];
    endfunction

endpackage

// File: rtl/pipe_ctrl_fwd_sel.sv
// Single-operand forwarding select: picks EXE_OUT, MEM_ACC_OUT or WB_OUT over the
// register file, youngest producer first; R0 is never forwarded.
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rd_ex,
    input  logic       i_wr_ex,
    input  logic       i_ex_load,
    input  logic [4:0] i_rd_mem,
    input  logic       i_wr_mem,
    input  logic [4:0] i_rd_wb,
    input  logic       i_wr_wb,
    output logic [1:0] o_fwd
);

    always_comb begin
        o_fwd = FWD_RF;
        if (i_rs != '0) begin
            // a load in EX has no data yet; the load-use stall covers it
            if (i_wr_ex && (i_rd_ex == i_rs) && !i_ex_load) begin
                o_fwd = FWD_EXE;
            end else if (i_wr_mem && (i_rd_mem == i_rs)) begin
                o_fwd = FWD_MEM;
            end else if (i_wr_wb && (i_rd_wb == i_rs)) begin
                o_fwd = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: load-use stall, branch squash, halt and operand forwarding.
// Optional perf counters (STALL_CNT/FLUSH_CNT) are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IR_ID,
    input  logic        ID_VALID,
    input  logic [4:0]  OPCD_EX,
    input  logic [4:0]  RD_EX,
    input  logic        WR_EX,
    input  logic [4:0]  RD_MEM,
    input  logic        WR_MEM,
    input  logic [4:0]  RD_WB,
    input  logic        COND_WB,
    input  logic        BR_TAKEN,
    output logic        STALL_IF,
    output logic        STALL_ID,
    output logic        FLUSH_ID,
    output logic        BUBBLE_EX,
    output logic [1:0]  FWD_A,
    output logic [1:0]  FWD_B,
    output logic [2:0]  ESTADO
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [DATA_W-1:0] STALL_CNT,
    output logic [DATA_W-1:0] FLUSH_CNT
`endif
);

    localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYC - 1);
    localparam bit         FLUSH_MULTI = (FLUSH_CYC > 1);

    state_t     r_state;
    state_t     w_next;
    state_t     w_br_state;
    logic [2:0] r_fcnt;
    logic [2:0] w_fcnt_next;
    logic [4:0] w_opc;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_ex_load;
    logic       w_load_use;
    logic       w_halt_id;
    logic       w_unused_ir;

    assign w_opc       = ir_opcode(IR_ID);
    assign w_rs1       = ir_rs1(IR_ID);
    assign w_rs2       = ir_rs2(IR_ID);
    assign w_unused_ir = ^{IR_ID[26:22], IR_ID[11:0]};

    assign w_ex_load  = (OPCD_EX == OP_LW);
    assign w_load_use = ID_VALID && w_ex_load && WR_EX && (RD_EX != '0) &&
                        ((RD_EX == w_rs1) || (RD_EX == w_rs2));
    assign w_halt_id  = ID_VALID && (w_opc == OP_HALT);

    // a single-cycle squash is fully covered by the combinational FLUSH_ID in RUN
    assign w_br_state = FLUSH_MULTI ? ST_FLUSH : ST_RUN;

    fwd_sel u_fwd_a (
        .i_rs      (w_rs1),
        .i_rd_ex   (RD_EX),
        .i_wr_ex   (WR_EX),
        .i_ex_load (w_ex_load),
        .i_rd_mem  (RD_MEM),
        .i_wr_mem  (WR_MEM),
        .i_rd_wb   (RD_WB),
        .i_wr_wb   (COND_WB),
        .o_fwd     (FWD_A)
    );

    fwd_sel u_fwd_b (
        .i_rs      (w_rs2),
        .i_rd_ex   (RD_EX),
        .i_wr_ex   (WR_EX),
        .i_ex_load (w_ex_load),
        .i_rd_mem  (RD_MEM),
        .i_wr_mem  (WR_MEM),
        .i_rd_wb   (RD_WB),
        .i_wr_wb   (COND_WB),
        .o_fwd     (FWD_B)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_next;
            r_fcnt  <= w_fcnt_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_fcnt_next = r_fcnt;
        STALL_IF    = 1'b0;
        STALL_ID    = 1'b0;
        FLUSH_ID    = 1'b0;
        BUBBLE_EX   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                STALL_IF  = 1'b1;
                STALL_ID  = 1'b1;
                BUBBLE_EX = 1'b1;
                w_next    = ST_RUN;
            end
            ST_RUN: begin
                // a taken branch makes the ID instruction wrong-path, so it outranks hazards
                if (BR_TAKEN) begin
                    FLUSH_ID    = 1'b1;
                    w_next      = w_br_state;
                    w_fcnt_next = FLUSH_LOAD;
                end else if (w_load_use) begin
                    STALL_IF  = 1'b1;
                    STALL_ID  = 1'b1;
                    BUBBLE_EX = 1'b1;
                    w_next    = ST_STALL;
                end else if (w_halt_id) begin
                    STALL_IF  = 1'b1;
                    STALL_ID  = 1'b1;
                    BUBBLE_EX = 1'b1;
                    w_next    = ST_HALT;
                end
            end
            ST_STALL: begin
                STALL_IF  = 1'b1;
                STALL_ID  = 1'b1;
                BUBBLE_EX = 1'b1;
                if (BR_TAKEN) begin
                    FLUSH_ID    = 1'b1;
                    w_next      = w_br_state;
                    w_fcnt_next = FLUSH_LOAD;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_FLUSH: begin
                FLUSH_ID = 1'b1;
                if (BR_TAKEN) begin
                    w_fcnt_next = FLUSH_LOAD;
                end else begin
                    w_fcnt_next = r_fcnt - 3'd1;
                    if (r_fcnt <= 3'd1) begin
                        w_next = ST_RUN;
                    end
                end
            end
            ST_HALT: begin
                STALL_IF  = 1'b1;
                STALL_ID  = 1'b1;
                BUBBLE_EX = 1'b1;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign ESTADO = r_state;

`ifdef PIPE_CTRL_PERF_EN
    logic [DATA_W-1:0] r_stall_cnt;
    logic [DATA_W-1:0] r_flush_cnt;
    logic              w_stall_evt;

    assign w_stall_evt = STALL_IF && (r_state != ST_IDLE) && (r_state != ST_HALT);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + DATA_W'(1);
            end
            if (FLUSH_ID && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + DATA_W'(1);
            end
        end
    end

    assign STALL_CNT = r_stall_cnt;
    assign FLUSH_CNT = r_flush_cnt;
`else
    logic [DATA_W-1:0] w_unused_perf;
    assign w_unused_perf = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (default FLUSH_CYC = 2).
module tb_pipe_ctrl;

    localparam logic [4:0] LW   = 5'd2;
    localparam logic [4:0] HALT = 5'd31;

    logic        CLK;
    logic        RST;
    logic [31:0] IR_ID;
    logic        ID_VALID;
    logic [4:0]  OPCD_EX;
    logic [4:0]  RD_EX;
    logic        WR_EX;
    logic [4:0]  RD_MEM;
    logic        WR_MEM;
    logic [4:0]  RD_WB;
    logic        COND_WB;
    logic        BR_TAKEN;
    logic        STALL_IF;
    logic        STALL_ID;
    logic        FLUSH_ID;
    logic        BUBBLE_EX;
    logic [1:0]  FWD_A;
    logic [1:0]  FWD_B;
    logic [2:0]  ESTADO;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] STALL_CNT;
    logic [15:0] FLUSH_CNT;
`endif

    int checks   = 0;
    int failures = 0;

    pipe_ctrl #(.DATA_W(16), .FLUSH_CYC(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IR_ID     (IR_ID),
        .ID_VALID  (ID_VALID),
        .OPCD_EX   (OPCD_EX),
        .RD_EX     (RD_EX),
        .WR_EX     (WR_EX),
        .RD_MEM    (RD_MEM),
        .WR_MEM    (WR_MEM),
        .RD_WB     (RD_WB),
        .COND_WB   (COND_WB),
        .BR_TAKEN  (BR_TAKEN),
        .STALL_IF  (STALL_IF),
        .STALL_ID  (STALL_ID),
        .FLUSH_ID  (FLUSH_ID),
        .BUBBLE_EX (BUBBLE_EX),
        .FWD_A     (FWD_A),
        .FWD_B     (FWD_B),
        .ESTADO    (ESTADO)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .STALL_CNT (STALL_CNT),
        .FLUSH_CNT (FLUSH_CNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        logic [31:0] ir;
        ir        = '0;
        ir[31:27] = opc;
        ir[21:17] = rs1;
        ir[16:12] = rs2;
        return ir;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock and settle just after the edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        IR_ID    = '0;
        ID_VALID = 1'b0;
        OPCD_EX  = '0;
        RD_EX    = '0;
        WR_EX    = 1'b0;
        RD_MEM   = '0;
        WR_MEM   = 1'b0;
        RD_WB    = '0;
        COND_WB  = 1'b0;
        BR_TAKEN = 1'b0;
    endtask

    task automatic set_load_use();
        IR_ID    = mk_ir(5'd0, 5'd3, 5'd10);
        ID_VALID = 1'b1;
        OPCD_EX  = LW;
        RD_EX    = 5'd10;
        WR_EX    = 1'b1;
    endtask

    initial begin
        clear_inputs();
        RST = 1'b0;
        step();
        step();
        chk("rst_estado", 16'(ESTADO), 16'd0);
        chk("rst_stall_if", 16'(STALL_IF), 16'd1);
        chk("rst_stall_id", 16'(STALL_ID), 16'd1);
        chk("rst_bubble", 16'(BUBBLE_EX), 16'd1);
        chk("rst_flush", 16'(FLUSH_ID), 16'd0);

        RST = 1'b1;
        step();
        chk("run_estado", 16'(ESTADO), 16'd1);
        chk("run_stall_if", 16'(STALL_IF), 16'd0);

        // forwarding priority, combinational
        IR_ID   = mk_ir(5'd0, 5'd5, 5'd7);
        RD_EX   = 5'd5; RD_MEM = 5'd5; RD_WB = 5'd5;
        WR_EX   = 1'b1; WR_MEM = 1'b1; COND_WB = 1'b1;
        #1;
        chk("fwd_a_ex", 16'(FWD_A), 16'd1);
        chk("fwd_b_none", 16'(FWD_B), 16'd0);
        WR_EX = 1'b0; #1;
        chk("fwd_a_mem", 16'(FWD_A), 16'd2);
        WR_MEM = 1'b0; #1;
        chk("fwd_a_wb", 16'(FWD_A), 16'd3);
        IR_ID = mk_ir(5'd0, 5'd0, 5'd7); #1;
        chk("fwd_a_r0", 16'(FWD_A), 16'd0);
        RD_EX = 5'd0; RD_MEM = 5'd0; RD_WB = 5'd0;
        WR_EX = 1'b1; WR_MEM = 1'b1; COND_WB = 1'b1; #1;
        chk("fwd_a_r0_match", 16'(FWD_A), 16'd0);
        IR_ID = mk_ir(5'd0, 5'd5, 5'd7);
        OPCD_EX = LW; RD_EX = 5'd5; RD_MEM = 5'd5; RD_WB = 5'd0; #1;
        chk("fwd_a_lw_skip", 16'(FWD_A), 16'd2);
        RD_WB = 5'd7; #1;
        chk("fwd_b_wb", 16'(FWD_B), 16'd3);
        clear_inputs();

        // load-use stall
        set_load_use(); #1;
        chk("lu_det_stall_if", 16'(STALL_IF), 16'd1);
        chk("lu_det_bubble", 16'(BUBBLE_EX), 16'd1);
        chk("lu_det_estado", 16'(ESTADO), 16'd1);
        step();
        OPCD_EX = 5'd0; WR_EX = 1'b0; RD_EX = 5'd0;
        RD_MEM = 5'd10; WR_MEM = 1'b1; #1;
        chk("lu_stall_estado", 16'(ESTADO), 16'd2);
        chk("lu_stall_if", 16'(STALL_IF), 16'd1);
        chk("lu_stall_id", 16'(STALL_ID), 16'd1);
        chk("lu_fwd_b_mem", 16'(FWD_B), 16'd2);
        step();
        chk("lu_after_estado", 16'(ESTADO), 16'd1);
        chk("lu_after_stall_if", 16'(STALL_IF), 16'd0);
        clear_inputs();

        // single branch
        BR_TAKEN = 1'b1; #1;
        chk("br_n_flush", 16'(FLUSH_ID), 16'd1);
        chk("br_n_estado", 16'(ESTADO), 16'd1);
        step();
        BR_TAKEN = 1'b0; #1;
        chk("br_n1_estado", 16'(ESTADO), 16'd3);
        chk("br_n1_flush", 16'(FLUSH_ID), 16'd1);
        step();
        chk("br_n2_estado", 16'(ESTADO), 16'd1);
        chk("br_n2_flush", 16'(FLUSH_ID), 16'd0);

        // back-to-back branches extend the squash
        BR_TAKEN = 1'b1; #1;
        chk("br2_n_flush", 16'(FLUSH_ID), 16'd1);
        step();
        chk("br2_n1_estado", 16'(ESTADO), 16'd3);
        chk("br2_n1_flush", 16'(FLUSH_ID), 16'd1);
        step();
        BR_TAKEN = 1'b0; #1;
        chk("br2_n2_estado", 16'(ESTADO), 16'd3);
        chk("br2_n2_flush", 16'(FLUSH_ID), 16'd1);
        step();
        chk("br2_n3_estado", 16'(ESTADO), 16'd1);
        chk("br2_n3_flush", 16'(FLUSH_ID), 16'd0);

        // branch + load-use + halt together: flush only
        IR_ID = mk_ir(HALT, 5'd10, 5'd0); ID_VALID = 1'b1;
        OPCD_EX = LW; RD_EX = 5'd10; WR_EX = 1'b1; BR_TAKEN = 1'b1; #1;
        chk("sim_flush", 16'(FLUSH_ID), 16'd1);
        chk("sim_stall_if", 16'(STALL_IF), 16'd0);
        chk("sim_bubble", 16'(BUBBLE_EX), 16'd0);
        step();
        clear_inputs(); #1;
        chk("sim_estado_flush", 16'(ESTADO), 16'd3);
        step();
        chk("sim_estado_run", 16'(ESTADO), 16'd1);

        // branch resolved during the stall cycle
        set_load_use();
        step();
        clear_inputs();
        BR_TAKEN = 1'b1; #1;
        chk("stbr_estado", 16'(ESTADO), 16'd2);
        chk("stbr_flush", 16'(FLUSH_ID), 16'd1);
        step();
        BR_TAKEN = 1'b0; #1;
        chk("stbr_next_estado", 16'(ESTADO), 16'd3);
        step();
        chk("stbr_run_estado", 16'(ESTADO), 16'd1);

        // reset in the middle of a flush
        BR_TAKEN = 1'b1;
        step();
        BR_TAKEN = 1'b0; RST = 1'b0;
        step();
        chk("rst_flush_estado", 16'(ESTADO), 16'd0);
        RST = 1'b1;
        step();
        chk("rst_flush_run", 16'(ESTADO), 16'd1);

        // halt is sticky until reset
        IR_ID = mk_ir(HALT, 5'd1, 5'd2); ID_VALID = 1'b1; #1;
        chk("halt_det_stall_if", 16'(STALL_IF), 16'd1);
        step();
        clear_inputs(); #1;
        chk("halt_estado", 16'(ESTADO), 16'd4);
        BR_TAKEN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("halt_stall_if_hold", 16'(STALL_IF), 16'd1);
        end
        chk("halt_estado_hold", 16'(ESTADO), 16'd4);
        BR_TAKEN = 1'b0;
        RST = 1'b0;
        step();
        chk("halt_rst_estado", 16'(ESTADO), 16'd0);
        RST = 1'b1;
        step();
        chk("halt_rst_run", 16'(ESTADO), 16'd1);

`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall_zero", STALL_CNT, 16'd0);
        chk("perf_flush_zero", FLUSH_CNT, 16'd0);
        for (int i = 0; i < 3; i++) begin
            set_load_use();
            step();
            clear_inputs();
            step();
        end
        for (int i = 0; i < 2; i++) begin
            BR_TAKEN = 1'b1;
            step();
            BR_TAKEN = 1'b0;
            step();
        end
        chk("perf_stall_cnt", STALL_CNT, 16'd6);
        chk("perf_flush_cnt", FLUSH_CNT, 16'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
